// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file: latches one retiring
// instruction per start pulse, commits it on the following edge, and serves two bypassed read ports.
module writeback_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stage5,
   input  logic                  regWrite,
   input  logic                  regDst,
   input  logic                  memToReg,
   input  logic [ADDR_WIDTH-1:0] rt,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] aluresult,
   input  logic [DATA_WIDTH-1:0] memvalue,
   input  logic [ADDR_WIDTH-1:0] readreg1,
   input  logic [ADDR_WIDTH-1:0] readreg2,
   output logic [DATA_WIDTH-1:0] readdata1,
   output logic [DATA_WIDTH-1:0] readdata2,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           retired,
   output logic                  overrun
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [DATA_WIDTH-1:0]   regs_r [DEPTH];
   logic [ADDR_WIDTH-1:0]   waddr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic                    wen_r;
   logic [ADDR_WIDTH-1:0]   waddr_s;
   logic [DATA_WIDTH-1:0]   wdata_s;
   logic                    wen_s;
   logic                    busy_r;
   logic                    done_r;
   logic                    overrun_r;
   logic [31:0]             retired_r;

   // Next-state logic and selection of the candidate write transaction.
   always_comb begin
      state_s = state_r;
      waddr_s = regDst ? rd : rt;
      wdata_s = memToReg ? memvalue : aluresult;
      wen_s   = regWrite && (waddr_s != '0);
      case (state_r)
         IDLE: begin
            if (stage5) begin
               state_s = WRITE;
            end else begin
               state_s = IDLE;
            end
         end
         WRITE:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, transaction latches, register array and status counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         waddr_r   <= '0;
         wdata_r   <= '0;
         wen_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         overrun_r <= 1'b0;
         retired_r <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (stage5) begin
                  waddr_r <= waddr_s;
                  wdata_r <= wdata_s;
                  wen_r   <= wen_s;
               end
            end
            WRITE: begin
               // wen_r is never set for index 0, so register 0 stays zero.
               if (wen_r) begin
                  regs_r[waddr_r] <= wdata_r;
               end
               retired_r <= retired_r + 32'd1;
               if (stage5) begin
                  overrun_r <= 1'b1;
               end
            end
            default: begin
               waddr_r <= waddr_r;
            end
         endcase
         state_r <= state_s;
         busy_r  <= (state_s == WRITE);
         done_r  <= (state_r == WRITE);
      end
   end

   // Read port 1: zero register, then pending-write bypass, then array.
   always_comb begin
      readdata1 = '0;
      if (readreg1 == '0) begin
         readdata1 = '0;
      end else if ((state_r == WRITE) && wen_r && (readreg1 == waddr_r)) begin
         readdata1 = wdata_r;
      end else begin
         readdata1 = regs_r[readreg1];
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      readdata2 = '0;
      if (readreg2 == '0) begin
         readdata2 = '0;
      end else if ((state_r == WRITE) && wen_r && (readreg2 == waddr_r)) begin
         readdata2 = wdata_r;
      end else begin
         readdata2 = regs_r[readreg2];
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign retired = retired_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: expected writebacks are queued at issue
// and checked against the read ports when done pulses.
module tb_writeback_regfile;

   typedef struct packed {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
   } sb_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        stage5;
   logic        regWrite;
   logic        regDst;
   logic        memToReg;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] aluresult;
   logic [31:0] memvalue;
   logic [4:0]  readreg1;
   logic [4:0]  readreg2;
   logic [31:0] readdata1;
   logic [31:0] readdata2;
   logic        busy;
   logic        done;
   logic [31:0] retired;
   logic        overrun;

   sb_t         sb_q [$];
   logic [31:0] model_regs [32];
   logic [31:0] model_retired;
   int          n_checks = 0;
   int          n_fail   = 0;

   writeback_regfile dut (
      .clock     (clock),
      .reset     (reset),
      .stage5    (stage5),
      .regWrite  (regWrite),
      .regDst    (regDst),
      .memToReg  (memToReg),
      .rt        (rt),
      .rd        (rd),
      .aluresult (aluresult),
      .memvalue  (memvalue),
      .readreg1  (readreg1),
      .readreg2  (readreg2),
      .readdata1 (readdata1),
      .readdata2 (readdata2),
      .busy      (busy),
      .done      (done),
      .retired   (retired),
      .overrun   (overrun)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_retired = 32'd0;
      sb_q.delete();
   endtask

   // Present one instruction for a single edge and queue its expected writeback.
   task automatic start_op(input logic wr, input logic dst, input logic m2r,
                           input logic [4:0] t, input logic [4:0] d,
                           input logic [31:0] alu, input logic [31:0] mem);
      sb_t it;
      regWrite  = wr;
      regDst    = dst;
      memToReg  = m2r;
      rt        = t;
      rd        = d;
      aluresult = alu;
      memvalue  = mem;
      stage5    = 1'b1;
      it.addr   = dst ? d : t;
      it.data   = m2r ? mem : alu;
      it.wen    = wr && (it.addr != 5'd0);
      sb_q.push_back(it);
      step();
      stage5 = 1'b0;
      check("busy_in_write", {31'd0, busy}, 32'd1);
   endtask

   // Wait (bounded) for done, then retire the oldest queued entry and compare.
   task automatic wait_done();
      int  n = 0;
      sb_t it;
      while (done !== 1'b1 && n < 4) begin
         step();
         n++;
      end
      check("done_latency", 32'(n), 32'd1);
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_after_write", {31'd0, busy}, 32'd0);
      if (done === 1'b1 && sb_q.size() > 0) begin
         it = sb_q.pop_front();
         if (it.wen) model_regs[it.addr] = it.data;
         model_retired = model_retired + 32'd1;
         readreg2 = it.addr;
         #1;
         check("wb_readback", readdata2, model_regs[it.addr]);
         check("retired", retired, model_retired);
      end
      step();
      check("done_width", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int dones;
      sb_t it;
      reset = 1'b1; stage5 = 1'b0; regWrite = 1'b0; regDst = 1'b0; memToReg = 1'b0;
      rt = 5'd0; rd = 5'd0; aluresult = 32'd0; memvalue = 32'd0;
      readreg1 = 5'd0; readreg2 = 5'd0;
      clear_model();
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_retired", retired, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         readreg1 = 5'(i);
         readreg2 = 5'(31 - i);
         #1;
         check("rst_read1", readdata1, 32'd0);
         check("rst_read2", readdata2, 32'd0);
      end

      // Load to rt=8 with bypass during WRITE
      start_op(1'b1, 1'b0, 1'b1, 5'd8, 5'd2, 32'h0000_0077, 32'hDEAD_BEEF);
      readreg1 = 5'd8;
      #1;
      check("bypass_load", readdata1, 32'hDEAD_BEEF);
      wait_done();
      readreg1 = 5'd8;
      #1;
      check("reg8_array", readdata1, 32'hDEAD_BEEF);

      // R-type to rd=0 is dropped but retires
      start_op(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 32'h0000_1234, 32'h0);
      readreg1 = 5'd0;
      #1;
      check("r0_bypass", readdata1, 32'd0);
      wait_done();
      readreg1 = 5'd0;
      #1;
      check("r0_after", readdata1, 32'd0);

      // regWrite=0 targeting reg 8 must neither bypass nor write
      start_op(1'b0, 1'b1, 1'b0, 5'd1, 5'd8, 32'hCAFE_F00D, 32'h0);
      readreg1 = 5'd8;
      #1;
      check("nowrite_nobypass", readdata1, 32'hDEAD_BEEF);
      wait_done();

      // ALU result to rt=17: bypass on port 2, other port unaffected
      start_op(1'b1, 1'b0, 1'b0, 5'd17, 5'd4, 32'hA5A5_5A5A, 32'h1111_1111);
      readreg1 = 5'd8;
      readreg2 = 5'd17;
      #1;
      check("bypass_port2", readdata2, 32'hA5A5_5A5A);
      check("port1_nomatch", readdata1, 32'hDEAD_BEEF);
      wait_done();
      check("overrun_clear", {31'd0, overrun}, 32'd0);

      // stage5 held 6 cycles: accepted on alternate edges
      regWrite = 1'b1; regDst = 1'b1; memToReg = 1'b0;
      rt = 5'd9; rd = 5'd3; aluresult = 32'd5; memvalue = 32'd99;
      it.wen = 1'b1; it.addr = 5'd3; it.data = 32'd5;
      for (int k = 0; k < 3; k++) sb_q.push_back(it);
      dones = 0;
      stage5 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         if (done === 1'b1 && sb_q.size() > 0) begin
            dones++;
            it = sb_q.pop_front();
            model_regs[it.addr] = it.data;
            model_retired = model_retired + 32'd1;
         end
      end
      stage5 = 1'b0;
      check("held_dones", 32'(dones), 32'd3);
      check("held_retired", retired, model_retired);
      check("held_overrun", {31'd0, overrun}, 32'd1);
      check("held_queue_empty", 32'(sb_q.size()), 32'd0);
      readreg1 = 5'd3;
      #1;
      check("held_reg3", readdata1, 32'd5);
      step();
      check("overrun_sticky", {31'd0, overrun}, 32'd1);

      // Reset on the WRITE cycle aborts the write
      start_op(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 32'h0000_0055, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_model();
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_retired", retired, 32'd0);
      check("abort_overrun", {31'd0, overrun}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("abort_no_done", {31'd0, done}, 32'd0);
      end
      readreg1 = 5'd9;
      readreg2 = 5'd8;
      #1;
      check("abort_reg9", readdata1, 32'd0);
      check("abort_reg8", readdata2, 32'd0);

      // Retired counter wrap
      force dut.retired_r = 32'hFFFF_FFFF;
      #1;
      release dut.retired_r;
      #1;
      model_retired = 32'hFFFF_FFFF;
      check("preload_retired", retired, 32'hFFFF_FFFF);
      start_op(1'b1, 1'b1, 1'b1, 5'd0, 5'd31, 32'h0, 32'h8000_0001);
      wait_done();
      check("wrap_retired", retired, 32'd0);
      readreg1 = 5'd31;
      #1;
      check("reg31", readdata1, 32'h8000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file for the MIPS pipeline. It sits directly downstream of the data-memory stage. It accepts one retiring instruction per start pulse, selects either the memory load value or the ALU result, and writes it to `rt` or `rd`. It also serves two combinational read ports to decode, with bypass of a pending write. A retired-instruction counter and a sticky overrun flag support debug and verification.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and data width
- `ADDR_WIDTH`, 5, register index width; the file holds 2^ADDR_WIDTH entries

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; one clock and a synchronous active-high reset are already decided
- `stage5`  in  1  start strobe from the memory stage; sampled each rising edge
- `regWrite`  in  1  1 = the instruction writes a register
- `regDst`  in  1  1 = destination is `rd`; 0 = destination is `rt`
- `memToReg`  in  1  1 = write `memvalue`; 0 = write `aluresult`
- `rt`, `rd`  in  ADDR_WIDTH each  candidate destination indices
- `aluresult`, `memvalue`  in  DATA_WIDTH each  candidate write data
- `readreg1`, `readreg2`  in  ADDR_WIDTH each  read-port indices
- `readdata1`, `readdata2`  out  DATA_WIDTH each  combinational read data
- `busy`  out  1  high while in WRITE
- `done`  out  1  one-cycle pulse after the register update
- `retired`  out  32  count of accepted instructions
- `overrun`  out  1  sticky; `stage5` arrived while busy

## Operation
- FSM with two states, IDLE and WRITE. Reset state is IDLE.
- IDLE, `stage5`=1:
  - latch `waddr` = `regDst` ? `rd` : `rt`
  - latch `wdata` = `memToReg` ? `memvalue` : `aluresult`
  - latch `wen` = `regWrite` && (`waddr` != 0)
  - go to WRITE
- IDLE, `stage5`=0: stay in IDLE.
- WRITE:
  - if `wen`, write `regs[waddr]` = `wdata`
  - `retired` increments by 1, modulo 2^32, and wraps 0xFFFFFFFF -> 0
  - `done` is high the next cycle
  - go to IDLE unconditionally
- Register 0 always reads 0. Writes to it are dropped, but the instruction still retires and still produces `done`.
- `regWrite`=0 retires with no register change.
- `stage5`=1 sampled in WRITE: the strobe is ignored, `overrun` is set, and the latched transaction is not disturbed. Only `reset` clears `overrun`.
- Read ports:
  - `readdataN` = `regs[readregN]`
  - bypass: while in WRITE with `wen`=1 and `readregN` == `waddr`, `readdataN` returns the latched `wdata`
  - index 0 always returns 0
- `reset` has priority over everything:
  - all registers, `retired`, `overrun`, `done`, `busy` and the latches go to 0
  - state goes to IDLE
  - an in-flight WRITE is aborted with no register update and no count
  - `stage5` coincident with `reset` is discarded

## Timing
- Reset values: every output is 0 (`readdata*` = 0 because all registers are 0).
- Edge E0 samples `stage5`=1 in IDLE. After E0: `busy`=1 and the bypass is active.
- Edge E1 performs the register write and the `retired` increment. After E1: `busy`=0, `done`=1 for exactly one cycle, and the read ports see the new value from the array.
- Latency is start edge to `done` = 2 edges. Throughput is one instruction per 2 cycles.
- The earliest next accept is the edge after E1, which is the cycle `done` is high. `stage5` held continuously is therefore accepted on alternate edges, and each rejected sample sets `overrun`.
- `done` and `busy` are registered. `readdata*` are combinational from the array, the latches and the index inputs.

## Test plan
- Reset, then read all 32 indices -> every read is 0; `retired`=0, `busy`=0, `done`=0, `overrun`=0.
- Load write (`stage5`, `regWrite`=1, `memToReg`=1, `regDst`=0, `rt`=8, `memvalue`=0xDEADBEEF):
  - during WRITE, `readreg1`=8 returns 0xDEADBEEF via the bypass
  - after E1, `done`=1 for 1 cycle and `regs[8]`=0xDEADBEEF
  - `retired`=1
- R-type write to `rd`=0 with `aluresult`=0x1234 -> `readdata` at index 0 stays 0, `done` pulses, `retired` increments.
- `stage5` held high for 6 cycles from IDLE with `rd`=3 and `aluresult`=5 -> 3 accepts, `retired`=3, `overrun`=1, `regs[3]`=5.
- `reset` asserted on the WRITE cycle of a write of 0x55 to register 9 -> `regs[9]`=0, `retired`=0, `done` never pulses.
- Force `retired`=0xFFFFFFFF (1 retire short of wrap) via back-to-back retires or a bench preload, then one more retire -> `retired`=0.
